clk_run_controller: RTL and testbench

//  Sequences the divided-clock generator feeding the Z80: free-run, halt, and N-cycle single-step bursts.

---
 rtl/clk_run_controller.sv | 155 +++++++++++++++
 tb/tb_clk_run_controller.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_run_controller.sv
// clk_run_controller
// Sequences the divided-clock generator feeding the Z80: free-run, halt and
// N-cycle single-step bursts. Issues 1-cycle start/stop strobes to the divider
// and watches the divider output for rising edges (one rise = one completed
// divided cycle).
//
// Optional feature: define CLK_RUN_CYCLE_COUNTER_EN to build the completed
// divided-cycle counter on o_cycle_count. Without it o_cycle_count is 0.
//
// Request handshake: i_run_stb / i_halt_stb / i_step_stb are single-cycle
// pulses sampled on the rising edge of i_clk; there is no ready/back-pressure,
// a request that the current state does not accept is simply dropped.
// Priority within one cycle is halt > step > run.

module clk_run_controller #(
    parameter int STEP_WIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic                  i_run_stb,
    input  logic                  i_halt_stb,
    input  logic                  i_step_stb,
    input  logic [STEP_WIDTH-1:0] i_step_count,
    input  logic                  i_div_clk,
    output logic                  o_start_stb,
    output logic                  o_stop_stb,
    output logic                  o_busy,
    output logic                  o_running,
    output logic                  o_done_stb,
    output logic [15:0]           o_cycle_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STEP = 2'd2,
        HALT = 2'd3
    } state_t;

    localparam logic [STEP_WIDTH-1:0] STEP_ONE = {{(STEP_WIDTH-1){1'b0}}, 1'b1};

    state_t                state;
    state_t                state_next;
    logic [STEP_WIDTH-1:0] step_cnt;
    logic [STEP_WIDTH-1:0] step_cnt_next;
    logic                  div_prev;
    logic                  rise;
    logic                  start_next;
    logic                  stop_next;
    logic                  done_next;

    // The divider idles high, so div_prev resets to 1 to avoid a false rise.
    assign rise = i_div_clk & ~div_prev;

    // Next-state and strobe decode; strobes are registered below so they
    // appear exactly one cycle after the request or final rise is sampled.
    always_comb begin
        state_next    = state;
        step_cnt_next = step_cnt;
        start_next    = 1'b0;
        stop_next     = 1'b0;
        done_next     = 1'b0;
        case (state)
            IDLE: begin
                if (i_halt_stb) begin
                    // halt has top priority and means nothing in IDLE
                end else if (i_step_stb) begin
                    if (i_step_count != '0) begin
                        state_next    = STEP;
                        step_cnt_next = i_step_count;
                        start_next    = 1'b1;
                    end else begin
                        done_next = 1'b1;
                    end
                end else if (i_run_stb) begin
                    state_next = RUN;
                    start_next = 1'b1;
                end
            end
            RUN: begin
                if (i_halt_stb) begin
                    state_next = HALT;
                    stop_next  = 1'b1;
                end
            end
            STEP: begin
                // Halt beats a same-cycle final rise (no done); run converts the
                // burst into free-run without touching the divider.
                if (i_halt_stb) begin
                    state_next = HALT;
                    stop_next  = 1'b1;
                end else if (i_run_stb) begin
                    state_next = RUN;
                end else if (rise) begin
                    if (step_cnt <= STEP_ONE) begin
                        state_next    = HALT;
                        step_cnt_next = '0;
                        stop_next     = 1'b1;
                        done_next     = 1'b1;
                    end else begin
                        step_cnt_next = step_cnt - STEP_ONE;
                    end
                end
            end
            HALT: begin
                // One dead cycle guarantees a gap between stop and next start.
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // State, edge detector and registered outputs.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state       <= IDLE;
            step_cnt    <= '0;
            div_prev    <= 1'b1;
            o_start_stb <= 1'b0;
            o_stop_stb  <= 1'b0;
            o_done_stb  <= 1'b0;
            o_busy      <= 1'b0;
            o_running   <= 1'b0;
        end else begin
            state       <= state_next;
            step_cnt    <= step_cnt_next;
            div_prev    <= i_div_clk;
            o_start_stb <= start_next;
            o_stop_stb  <= stop_next;
            o_done_stb  <= done_next;
            o_busy      <= (state_next != IDLE);
            o_running   <= (state_next == RUN);
        end
    end

`ifdef CLK_RUN_CYCLE_COUNTER_EN
    logic [15:0] cycle_cnt;

    // Count completed divided cycles while clocking; clear alongside each start.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            cycle_cnt <= 16'h0000;
        end else if (start_next) begin
            cycle_cnt <= 16'h0000;
        end else if (rise && (state == RUN || state == STEP) && cycle_cnt != 16'hFFFF) begin
            cycle_cnt <= cycle_cnt + 16'h0001;
        end
    end

    assign o_cycle_count = cycle_cnt;
`else
    assign o_cycle_count = 16'h0000;
`endif

endmodule

// File: tb/tb_clk_run_controller.sv
// tb_clk_run_controller
// Directed bench for clk_run_controller. Inputs change 1 ns after the rising
// edge and outputs are checked at the same point, so every check sees the
// result of the edge just taken. The divider output is driven by hand.

module tb_clk_run_controller;

    localparam int STEP_WIDTH = 8;

`ifdef CLK_RUN_CYCLE_COUNTER_EN
    localparam bit CC_EN = 1'b1;
`else
    localparam bit CC_EN = 1'b0;
`endif

    logic                  i_clk;
    logic                  i_reset_n;
    logic                  i_run_stb;
    logic                  i_halt_stb;
    logic                  i_step_stb;
    logic [STEP_WIDTH-1:0] i_step_count;
    logic                  i_div_clk;
    logic                  o_start_stb;
    logic                  o_stop_stb;
    logic                  o_busy;
    logic                  o_running;
    logic                  o_done_stb;
    logic [15:0]           o_cycle_count;

    int n_vec = 0;
    int n_err = 0;

    clk_run_controller #(.STEP_WIDTH(STEP_WIDTH)) dut (
        .i_clk         (i_clk),
        .i_reset_n     (i_reset_n),
        .i_run_stb     (i_run_stb),
        .i_halt_stb    (i_halt_stb),
        .i_step_stb    (i_step_stb),
        .i_step_count  (i_step_count),
        .i_div_clk     (i_div_clk),
        .o_start_stb   (o_start_stb),
        .o_stop_stb    (o_stop_stb),
        .o_busy        (o_busy),
        .o_running     (o_running),
        .o_done_stb    (o_done_stb),
        .o_cycle_count (o_cycle_count)
    );

    // clock
    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // One divided cycle: low for one edge, then high; the rise is seen on the second edge.
    task automatic div_cycle();
        i_div_clk = 1'b0;
        tick();
        i_div_clk = 1'b1;
        tick();
    endtask

    task automatic check_outs(input string tag, input logic start, input logic stop,
                              input logic busy, input logic running, input logic done);
        check({tag, "_start"},   o_start_stb, start);
        check({tag, "_stop"},    o_stop_stb,  stop);
        check({tag, "_busy"},    o_busy,      busy);
        check({tag, "_running"}, o_running,   running);
        check({tag, "_done"},    o_done_stb,  done);
    endtask

    // Strobe invariants, checked every cycle on the falling edge.
    logic prev_start = 1'b0;
    logic prev_stop  = 1'b0;
    always @(negedge i_clk) begin
        if (i_reset_n) begin
            check("inv_start_and_stop", o_start_stb & o_stop_stb, 1'b0);
            check("inv_back_to_back", (o_start_stb & prev_start) | (o_stop_stb & prev_stop), 1'b0);
            prev_start = o_start_stb;
            prev_stop  = o_stop_stb;
        end else begin
            prev_start = 1'b0;
            prev_stop  = 1'b0;
        end
    end

    initial begin
        i_reset_n    = 1'b0;
        i_run_stb    = 1'b0;
        i_halt_stb   = 1'b0;
        i_step_stb   = 1'b0;
        i_step_count = '0;
        i_div_clk    = 1'b1;

        // reset state
        #2;
        check_outs("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("reset_cycle_count", o_cycle_count, 16'h0000);
        tick();
        tick();
        i_reset_n = 1'b1;
        tick();
        check_outs("idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // free-run then halt
        i_run_stb = 1'b1;
        tick();
        i_run_stb = 1'b0;
        check_outs("run_t1", 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        tick();
        check_outs("run_t2", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        div_cycle();
        check("run_cycle_count", o_cycle_count, CC_EN ? 32'd1 : 32'd0);
        i_halt_stb = 1'b1;
        tick();
        i_halt_stb = 1'b0;
        check_outs("halt_t1", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        check_outs("halt_t2", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("halt_cycle_hold", o_cycle_count, CC_EN ? 32'd1 : 32'd0);

        // step burst of 3
        i_step_stb   = 1'b1;
        i_step_count = 8'd3;
        tick();
        i_step_stb = 1'b0;
        check_outs("step3_start", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        check("step3_cc_clear", o_cycle_count, 16'h0000);
        div_cycle();
        check_outs("step3_rise1", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        div_cycle();
        check_outs("step3_rise2", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        div_cycle();
        check_outs("step3_rise3", 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        check("step3_cycle_count", o_cycle_count, CC_EN ? 32'd3 : 32'd0);
        tick();
        check_outs("step3_idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // zero-length step
        i_step_stb   = 1'b1;
        i_step_count = 8'd0;
        tick();
        i_step_stb = 1'b0;
        check_outs("step0_t1", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        check_outs("step0_t2", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // all three requests together in IDLE
        i_run_stb    = 1'b1;
        i_step_stb   = 1'b1;
        i_halt_stb   = 1'b1;
        i_step_count = 8'd2;
        tick();
        i_run_stb  = 1'b0;
        i_step_stb = 1'b0;
        i_halt_stb = 1'b0;
        check_outs("all3", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // run + step together: step wins
        i_run_stb    = 1'b1;
        i_step_stb   = 1'b1;
        i_step_count = 8'd2;
        tick();
        i_run_stb  = 1'b0;
        i_step_stb = 1'b0;
        check_outs("run_step", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        // run during STEP converts to RUN with no strobe
        i_run_stb = 1'b1;
        tick();
        i_run_stb = 1'b0;
        check_outs("step_to_run", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        div_cycle();
        div_cycle();
        check_outs("run_no_done", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        i_halt_stb = 1'b1;
        tick();
        i_halt_stb = 1'b0;
        check_outs("halt2_t1", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        // run during the HALT cycle is dropped
        i_run_stb = 1'b1;
        tick();
        i_run_stb = 1'b0;
        check_outs("run_in_halt", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        // reissued one cycle later it is accepted
        i_run_stb = 1'b1;
        tick();
        i_run_stb = 1'b0;
        check_outs("run_reissue", 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        tick();
        i_halt_stb = 1'b1;
        tick();
        i_halt_stb = 1'b0;
        tick();
        check_outs("halt3_idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // halt beats a same-cycle final rise: stop without done
        i_step_stb   = 1'b1;
        i_step_count = 8'd1;
        tick();
        i_step_stb = 1'b0;
        i_div_clk  = 1'b0;
        tick();
        i_div_clk  = 1'b1;
        i_halt_stb = 1'b1;
        tick();
        i_halt_stb = 1'b0;
        check_outs("halt_vs_rise", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();

        // reset asserted mid-STEP clears outputs immediately
        i_step_stb   = 1'b1;
        i_step_count = 8'd5;
        tick();
        i_step_stb = 1'b0;
        check("pre_reset_start", o_start_stb, 1'b1);
        #2;
        i_reset_n = 1'b0;
        #1;
        check_outs("mid_reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("mid_reset_cc", o_cycle_count, 16'h0000);
        tick();
        i_reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_outs("post_reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
